// File: rtl/sc_pkg.sv
// Shared stochastic-computing package: FSM state encoding, default window size
// and width helpers used by the bitstream decoder and the number generators.
package sc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } scState_e;

   localparam int SC_WINDOW_LOG2_DEFAULT = 8;

   // Ones count spans 0..N inclusive, so it needs one bit more than log2(N).
   function automatic int scCountWidth(input int windowLog2);
      return windowLog2 + 1;
   endfunction

   // Result must also hold -N..+N in bipolar form, hence one more bit again.
   function automatic int scValueWidth(input int windowLog2);
      return windowLog2 + 2;
   endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Sample counter for one decode window: counts accepted samples modulo N and
// flags the last sample of the window (count == N-1).
module sc_window_counter
   import sc_pkg::*;
#(
   parameter int WINDOW_LOG2 = SC_WINDOW_LOG2_DEFAULT
)(
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   logic [WINDOW_LOG2-1:0] r_count;

   // Clear wins over enable so an abort never lets a stale sample slip in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + WINDOW_LOG2'(1);
      end
   end

   assign o_terminal = &r_count;

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary converter: counts ones over a window of N = 2^WINDOW_LOG2
// accepted samples and hands the result out over a valid/ready handshake.
// Define SC_BIPOLAR_EN to encode the result as 2*count - N (two's complement);
// otherwise the result is the plain ones count.
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int WINDOW_LOG2 = SC_WINDOW_LOG2_DEFAULT
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WINDOW_LOG2+1:0] value
);

   localparam int COUNT_W  = scCountWidth(WINDOW_LOG2);
   localparam int VALUE_W  = scValueWidth(WINDOW_LOG2);
   localparam int WINDOW_N = 1 << WINDOW_LOG2;

   scState_e           r_state;
   logic               r_busy;
   logic               r_outValid;
   logic [VALUE_W-1:0] r_value;
   logic [COUNT_W-1:0] r_onesCount;

   logic               w_sampleEnable;
   logic               w_sampleClear;
   logic               w_terminal;
   logic [COUNT_W-1:0] w_finalCount;
   logic [VALUE_W-1:0] w_latchValue;

   assign w_sampleEnable = (r_state == ACCUM) && bit_valid && !abort;
   assign w_sampleClear  = abort || (r_state != ACCUM);
   assign w_finalCount   = r_onesCount + COUNT_W'(bit_in);

`ifdef SC_BIPOLAR_EN
   assign w_latchValue = {w_finalCount, 1'b0} - VALUE_W'(WINDOW_N);
`else
   assign w_latchValue = {1'b0, w_finalCount};
`endif

   sc_window_counter #(
      .WINDOW_LOG2 (WINDOW_LOG2)
   ) u_windowCounter (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_sampleClear),
      .i_enable   (w_sampleEnable),
      .o_terminal (w_terminal)
   );

   // Window FSM with registered busy/out_valid, ones counter and result latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_outValid  <= 1'b0;
         r_value     <= '0;
         r_onesCount <= '0;
      end else if (abort) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_outValid  <= 1'b0;
         r_onesCount <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= ACCUM;
                  r_busy      <= 1'b1;
                  r_onesCount <= '0;
               end
            end
            ACCUM: begin
               if (bit_valid) begin
                  if (w_terminal) begin
                     r_state     <= HOLD;
                     r_busy      <= 1'b0;
                     r_outValid  <= 1'b1;
                     r_value     <= w_latchValue;
                     r_onesCount <= '0;
                  end else begin
                     r_onesCount <= w_finalCount;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  if (start) begin
                     r_state     <= ACCUM;
                     r_busy      <= 1'b1;
                     r_onesCount <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_busy     <= 1'b0;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign out_valid = r_outValid;
   assign value     = r_value;

endmodule

// File: doc/sc_bitstream_decoder.md
# sc_bitstream_decoder

Stochastic-to-binary converter: the counterpart to the LFSR-based stochastic number generators. It counts the 1s in a fixed-length window of a stochastic bitstream and presents the result as a binary value. It sits at the output of each stochastic compute lane, feeding results back to the binary domain over a valid/ready handshake.

## Interface
- `WINDOW_LOG2`, default 8: window length N = 2^WINDOW_LOG2 accepted samples; legal range 2..16.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a new window; single-cycle pulse.
- `abort` in 1: synchronous cancel of any window or held result.
- `bit_in` in 1: stochastic bitstream sample.
- `bit_valid` in 1: `bit_in` is a sample this cycle.
- `busy` out 1: window accumulation in progress.
- `out_valid` out 1: `value` holds a finished result.
- `out_ready` in 1: consumer accepts `value`.
- `value` out WINDOW_LOG2+2: result; format set by Configuration.

## Operation
- FSM states:
  - IDLE: `busy`=0, `out_valid`=0.
  - ACCUM: `busy`=1.
  - HOLD: `out_valid`=1, `value` stable.
- IDLE, `start`=1 → ACCUM. Ones counter and sample counter clear to 0.
- ACCUM, `bit_valid`=1:
  - Sample counter increments.
  - Ones counter adds `bit_in`.
  - Cycles with `bit_valid`=0 are ignored (gaps are legal and unbounded).
- ACCUM, Nth accepted sample (sample counter = N-1 and `bit_valid`=1) → HOLD. The result register latches ones count + `bit_in`.
- Ones count range is 0..N, so the counter is WINDOW_LOG2+1 bits wide. No overflow is possible.
- HOLD, `out_ready`=1:
  - Handshake completes.
  - With `start`=1 in the same cycle → ACCUM with cleared counters (back-to-back windows).
  - Otherwise → IDLE.
- HOLD, `out_ready`=0: stay in HOLD. `value` must not change.
- `start` in ACCUM, or in HOLD without `out_ready`, is ignored and not queued.
- `abort`=1 in any state → IDLE and counters clear. `abort` has priority over `start`, `bit_valid` and `out_ready`.
  - An abort in HOLD drops the result, so no handshake occurs.
- Reset values: state IDLE, `busy`=0, `out_valid`=0, `value`=0, all counters 0.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- `busy` rises the cycle after `start` is sampled in IDLE.
- `out_valid` rises and `busy` falls together, the cycle after the Nth accepted sample.
- Minimum window latency: `start` → `out_valid` = N+1 cycles, with `bit_valid` held high from the cycle after `start`.
- The sample presented in the `start` cycle is not counted.
- `out_valid` falls the cycle after the `out_ready` handshake. On a back-to-back restart, `busy` rises in that same cycle.
- `abort` takes effect on the next edge.
- `rst` asserted mid-window clears immediately (asynchronously). The partial count is lost.

## Configuration
- Macro `SC_BIPOLAR_EN`.
- Undefined (unipolar encoding):
  - `value` = ones count, zero-extended.
  - Range 0..N.
- Defined (bipolar encoding):
  - `value` = 2·count − N, two's complement.
  - Range −N..+N.
  - Computed at latch time, so it adds no output latency.
- Port widths are identical in both builds.

## Structure
- Shared package `sc_pkg`:
  - FSM state enum (IDLE/ACCUM/HOLD).
  - Default `WINDOW_LOG2`.
  - Width helper constants.
  - This package is shared with the stochastic number generators.
- One sub-module, `sc_window_counter`:
  - WINDOW_LOG2-bit sample counter with enable and synchronous clear.
  - Outputs a terminal flag at N-1.
- The FSM, ones counter and result register live in `sc_bitstream_decoder`.

## Test plan
All cases use WINDOW_LOG2=8, N=256.
- **All ones:** `start`, then 256 cycles of `bit_valid`=1, `bit_in`=1 → `out_valid` on cycle 257.
  - Unipolar `value`=256 (10'h100).
  - Bipolar `value`=+256.
- **Alternating and all-zeros streams:**
  - Alternating 1/0 stream → unipolar 128; bipolar 0.
  - All-zeros stream → unipolar 0; bipolar −256 (10'h300).
- **Gapped valid with backpressure:** `bit_valid` toggled every other cycle, stream of 64 ones and 192 zeros.
  - `out_valid` rises after 512 cycles; `value`=64.
  - Hold `out_ready`=0 for 10 cycles → `value` stable, `out_valid` stays high.
- **Back-to-back windows:** `out_ready`=1 together with `start` in HOLD.
  - The next window starts with no IDLE cycle.
  - The second result is independent of the first (e.g. 200 then 17).
- **Abort mid-window:** `abort` after 100 samples → IDLE, no `out_valid`.
  - A following window of 256 ones returns 256, not 356.
- **Reset mid-window and ignored start:** `rst` pulsed mid-window → all outputs 0 immediately. A `start` during ACCUM is ignored, with no extra window afterward.
